snoop_bus_arbiter: RTL and testbench
====================================

// Module: snoop_bus_arbiter
// PURPOSE
//  Round-robin owner of the shared snoop bus (Address_Com, BusRd/BusRdX/Invalidate, Shared) for the
//  4-core MESI system. Takes miss/upgrade requests from each core's cache controller and grants one
//  core at a time. Broadcasts the winner's op to all snoopers and aggregates the other cores' hits
//  into Shared. Waits for memory when data is needed, then retires the transaction.
// PARAMETERS
//  NUM_CORES     4    requesters/snoopers (power of 2, >=2)
//  ADDRESSSIZE   32   address width, same as `ADDRESSSIZE
//  SNOOP_CYCLES  2    cycles the bus op is broadcast before Shared is sampled (1..15)
//  MEM_TIMEOUT   64   max cycles waiting for Mem_ready before error retire (2..255)
// PORTS
//  clk          in   1                      clock, rising edge
//  rst_n        in   1                      asynchronous active-low reset
//  Bus_req      in   NUM_CORES              per-core request, held until that core sees Bus_done
//  Bus_op       in   2*NUM_CORES            per-core op, core i at [2i+1:2i]: 01 BusRd, 10 BusRdX, 11 Invalidate
//  Req_address  in   ADDRESSSIZE*NUM_CORES  per-core address, core i at [ADDRESSSIZE*(i+1)-1 : ADDRESSSIZE*i]
//  Snoop_hit    in   NUM_CORES              core i holds the broadcast block in S/E/M
//  Mem_ready    in   1                      memory has data for the current BusRd/BusRdX (1-cycle pulse)
//  Grant        out  NUM_CORES              one-hot current bus owner
//  BusRd        out  1                      broadcast BusRd
//  BusRdX       out  1                      broadcast BusRdX
//  Invalidate   out  1                      broadcast Invalidate
//  Address_Com  out  ADDRESSSIZE            broadcast address
//  Shared       out  1                      another core hit; valid from end of SNOOP until Bus_done
//  Bus_done     out  1                      1-cycle retire pulse to the granted core
//  Bus_err      out  1                      with Bus_done: memory timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, RR pointer = core 0, counters 0. Async assert clears the
//   in-flight transaction with no Bus_done.
//  FSM IDLE -> SNOOP -> [WAIT_MEM] -> DONE -> IDLE. All outputs are registered.
//  IDLE: if any Bus_req with op != 00, on the next edge grant the first requester at or after the RR
//   pointer (wrapping NUM_CORES-1 -> 0). Latch its op and address, raise Grant and the op line,
//   and enter SNOOP. Requests with op=00 are ignored.
//  SNOOP: op line, Address_Com and Grant held stable for SNOOP_CYCLES cycles. On the last cycle,
//   Shared <= |(Snoop_hit & ~Grant). The granted core's own hit is never counted.
//   Next state: WAIT_MEM for BusRd/BusRdX, DONE for Invalidate. Op lines drop when SNOOP is left.
//  WAIT_MEM: counts cycles. Mem_ready -> DONE. If the count reaches MEM_TIMEOUT -> DONE with
//   Bus_err=1. A Mem_ready arriving in the same cycle as the timeout is a success (Bus_err=0).
//  DONE: Bus_done=1 for exactly 1 cycle. Grant and Shared are still held; RR pointer <= granted+1 mod N.
//   Next cycle: Grant, Shared, Bus_err, Address_Com return to 0; state IDLE.
//  Latency, uncontended Invalidate (SNOOP_CYCLES=2): req edge0 -> Grant edge1 -> SNOOP 2 cycles ->
//   Bus_done edge3 -> IDLE edge4. At least 1 IDLE cycle between transactions.
//  Bus_req/Bus_op changes while a transaction is in flight do not affect it. Mem_ready outside
//   WAIT_MEM is ignored. At most one of BusRd/BusRdX/Invalidate is high at any time.
// STRUCTURE
//  cache_def_0.v additions: BUS_OP_NONE/BUSRD/BUSRDX/INV encodings, arbiter state encodings,
//   NUM_CORES define.
//  Sub-module rr_arbiter: combinational grant from (req, pointer), one-hot out. Parameter NUM_CORES.
//  Top: FSM, SNOOP/timeout counter, op/address latch, Shared register, RR pointer register.
// TESTING
//  1 Single BusRd: core2 req op=01 addr=0x0000_1A40, Snoop_hit=4'b0010, Mem_ready 3 cycles into
//    WAIT_MEM -> Grant=0100, BusRd for 2 cycles, Address_Com=0x1A40, Shared=1, Bus_done 1 cycle.
//  2 Contention: cores 0,1,3 req together, pointer=0 -> grant order 0,1,3. Each gets exactly one
//    Bus_done. Grant is never multi-hot. Pointer=0 at the end.
//  3 Invalidate: core1 op=11 with Snoop_hit=4'b0011 -> no WAIT_MEM, Shared=1 (core0 only),
//    Bus_done at 3 cycles after Grant.
//  4 Self-hit only: core3 BusRdX with Snoop_hit=4'b1000 -> Shared=0.
//  5 Timeout: BusRd, no Mem_ready -> Bus_done and Bus_err after 64 WAIT_MEM cycles. Same test with
//    Mem_ready on the 64th cycle -> Bus_err=0.
//  6 Reset mid-WAIT_MEM: rst_n low async -> all outputs 0 immediately, no Bus_done. After release,
//    a pending core0 req is granted.

Source files
------------

// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared encodings for the 4-core MESI snoop bus arbiter: bus ops, FSM states,
// default sizing and the op-to-broadcast-line decode.
package snoop_bus_arbiter_pkg;

    localparam int SBA_NUM_CORES    = 4;
    localparam int SBA_ADDRESSSIZE  = 32;
    localparam int SBA_SNOOP_CYCLES = 2;
    localparam int SBA_MEM_TIMEOUT  = 64;

    // Bit positions of the broadcast lines inside the 3-bit line vector.
    localparam int LINE_RD  = 0;
    localparam int LINE_RDX = 1;
    localparam int LINE_INV = 2;

    typedef enum logic [1:0] {
        BUS_OP_NONE   = 2'b00,
        BUS_OP_BUSRD  = 2'b01,
        BUS_OP_BUSRDX = 2'b10,
        BUS_OP_INV    = 2'b11
    } bus_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_SNOOP    = 2'b01,
        ARB_WAIT_MEM = 2'b10,
        ARB_DONE     = 2'b11
    } arb_state_e;

    function automatic logic [2:0] op_lines(input bus_op_e op);
        logic [2:0] lines;
        case (op)
            BUS_OP_BUSRD:  lines = 3'b001;
            BUS_OP_BUSRDX: lines = 3'b010;
            BUS_OP_INV:    lines = 3'b100;
            default:       lines = 3'b000;
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer,
// wrapping from NUM_CORES-1 back to 0. Produces one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_CORES-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 vld_o
);

    logic [IDX_W-1:0] cand_s;

    // Scan from the pointer; index arithmetic wraps naturally since NUM_CORES is a power of 2.
    always_comb begin
        cand_s = '0;
        idx_o  = '0;
        vld_o  = 1'b0;
        gnt_o  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand_s = ptr_i + IDX_W'(i);
            idx_o  = (!vld_o && req_i[cand_s]) ? cand_s : idx_o;
            vld_o  = vld_o | req_i[cand_s];
        end
        if (vld_o) begin
            gnt_o[idx_o] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the shared snoop bus: grants one core, broadcasts its op and address,
// aggregates the other cores' hits into Shared, waits for memory when needed, then retires.
module snoop_bus_arbiter
    import snoop_bus_arbiter_pkg::*;
#(
    parameter int NUM_CORES    = SBA_NUM_CORES,
    parameter int ADDRESSSIZE  = SBA_ADDRESSSIZE,
    parameter int SNOOP_CYCLES = SBA_SNOOP_CYCLES,
    parameter int MEM_TIMEOUT  = SBA_MEM_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CORES-1:0]             Bus_req,
    input  logic [2*NUM_CORES-1:0]           Bus_op,
    input  logic [ADDRESSSIZE*NUM_CORES-1:0] Req_address,
    input  logic [NUM_CORES-1:0]             Snoop_hit,
    input  logic                             Mem_ready,
    output logic [NUM_CORES-1:0]             Grant,
    output logic                             BusRd,
    output logic                             BusRdX,
    output logic                             Invalidate,
    output logic [ADDRESSSIZE-1:0]           Address_Com,
    output logic                             Shared,
    output logic                             Bus_done,
    output logic                             Bus_err
);

    localparam int               IDX_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int               CNT_W      = 8;
    localparam logic [CNT_W-1:0] SNOOP_LAST = CNT_W'(SNOOP_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEM_LAST   = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    logic [NUM_CORES-1:0]   req_vld_s;
    logic [NUM_CORES-1:0]   arb_gnt_s;
    logic [IDX_W-1:0]       arb_idx_s;
    logic                   arb_any_s;
    bus_op_e                req_op_s   [NUM_CORES];
    logic [ADDRESSSIZE-1:0] req_addr_s [NUM_CORES];

    arb_state_e             state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [ADDRESSSIZE-1:0] addr_q,   addr_d;
    logic [NUM_CORES-1:0]   grant_q,  grant_d;
    logic [IDX_W-1:0]       gidx_q,   gidx_d;
    logic [IDX_W-1:0]       ptr_q,    ptr_d;
    logic [2:0]             lines_q,  lines_d;
    logic                   shared_q, shared_d;
    logic                   done_q,   done_d;
    logic                   err_q,    err_d;

    // Op 00 is not a bus transaction, so such a request never competes.
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
        assign req_op_s[gi]   = bus_op_e'(Bus_op[2*gi +: 2]);
        assign req_addr_s[gi] = Req_address[ADDRESSSIZE*gi +: ADDRESSSIZE];
        assign req_vld_s[gi]  = Bus_req[gi] & (req_op_s[gi] != BUS_OP_NONE);
    end

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .req_i (req_vld_s),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s),
        .vld_o (arb_any_s)
    );

    // Transaction FSM: next state plus all next-cycle output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        lines_d  = lines_q;
        shared_d = shared_q;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            ARB_IDLE: begin
                if (arb_any_s) begin
                    state_d  = ARB_SNOOP;
                    grant_d  = arb_gnt_s;
                    gidx_d   = arb_idx_s;
                    addr_d   = req_addr_s[arb_idx_s];
                    lines_d  = op_lines(req_op_s[arb_idx_s]);
                    cnt_d    = '0;
                    shared_d = 1'b0;
                    err_d    = 1'b0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_SNOOP: begin
                if (cnt_q == SNOOP_LAST) begin
                    // The owner's own hit says nothing about other sharers.
                    shared_d = |(Snoop_hit & ~grant_q);
                    lines_d  = 3'b000;
                    cnt_d    = '0;
                    if (lines_q[LINE_INV]) begin
                        state_d = ARB_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ARB_WAIT_MEM;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ARB_WAIT_MEM: begin
                if (Mem_ready) begin
                    state_d = ARB_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (cnt_q == MEM_LAST) begin
                    state_d = ARB_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ARB_DONE: begin
                state_d  = ARB_IDLE;
                grant_d  = '0;
                addr_d   = '0;
                lines_d  = 3'b000;
                shared_d = 1'b0;
                err_d    = 1'b0;
                cnt_d    = '0;
                ptr_d    = gidx_q + IDX_ONE;
            end
            default: begin
                state_d  = ARB_IDLE;
                grant_d  = '0;
                addr_d   = '0;
                lines_d  = 3'b000;
                shared_d = 1'b0;
                err_d    = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // State and output registers; async reset drops any in-flight transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            grant_q  <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            lines_q  <= 3'b000;
            shared_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            lines_q  <= lines_d;
            shared_q <= shared_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign Grant       = grant_q;
    assign BusRd       = lines_q[LINE_RD];
    assign BusRdX      = lines_q[LINE_RDX];
    assign Invalidate  = lines_q[LINE_INV];
    assign Address_Com = addr_q;
    assign Shared      = shared_q;
    assign Bus_done    = done_q;
    assign Bus_err     = err_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench: stimulus pushes expected retirements, a monitor process tracks each
// granted transaction and compares it when Bus_done appears.
module tb_snoop_bus_arbiter;
    import snoop_bus_arbiter_pkg::*;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int SC = 2;
    localparam int MT = 64;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [NC-1:0]     Bus_req;
    logic [2*NC-1:0]   Bus_op;
    logic [AW*NC-1:0]  Req_address;
    logic [NC-1:0]     Snoop_hit;
    logic              Mem_ready;
    logic [NC-1:0]     Grant;
    logic              BusRd, BusRdX, Invalidate;
    logic [AW-1:0]     Address_Com;
    logic              Shared, Bus_done, Bus_err;

    snoop_bus_arbiter #(
        .NUM_CORES(NC), .ADDRESSSIZE(AW), .SNOOP_CYCLES(SC), .MEM_TIMEOUT(MT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .Bus_req(Bus_req), .Bus_op(Bus_op),
        .Req_address(Req_address), .Snoop_hit(Snoop_hit), .Mem_ready(Mem_ready),
        .Grant(Grant), .BusRd(BusRd), .BusRdX(BusRdX), .Invalidate(Invalidate),
        .Address_Com(Address_Com), .Shared(Shared), .Bus_done(Bus_done), .Bus_err(Bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  grant;
        logic [2:0]  lines;   // {Invalidate, BusRdX, BusRd}
        logic [31:0] addr;
        logic        shared;
        logic        err;
        int          lat;     // Grant-high cycles up to and including the Bus_done cycle
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   stim_timeouts = 0;
    bit   stim_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: tracks the bus owner's transaction and checks it against the scoreboard.
    bit          trk = 1'b0;
    bit          post = 1'b0;
    int          cyc = 0;
    int          opc = 0;
    logic [3:0]  t_grant;
    logic [31:0] t_addr;
    logic [2:0]  t_lines;
    exp_t        e;

    always begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            #1;
            chk("reset_outputs", 32'({Grant, BusRd, BusRdX, Invalidate, Shared, Bus_done, Bus_err}), 32'h0);
            chk("reset_address", Address_Com, 32'h0);
            trk  = 1'b0;
            post = 1'b0;
        end else begin
            chk("grant_onehot0", 32'($onehot0(Grant)), 32'h1);
            chk("op_lines_excl", 32'($countones({Invalidate, BusRdX, BusRd}) <= 1), 32'h1);
            if (post) begin
                chk("idle_after_done", 32'({Grant, Shared, Bus_err, Bus_done}), 32'h0);
                chk("idle_address", Address_Com, 32'h0);
                post = 1'b0;
            end
            if (!trk) begin
                if (Grant != 4'b0000) begin
                    trk     = 1'b1;
                    cyc     = 1;
                    t_grant = Grant;
                    t_addr  = Address_Com;
                    t_lines = {Invalidate, BusRdX, BusRd};
                    opc     = (t_lines != 3'b000) ? 1 : 0;
                end
            end else begin
                cyc++;
                if ({Invalidate, BusRdX, BusRd} != 3'b000) opc++;
                chk("grant_stable", 32'(Grant), 32'(t_grant));
                chk("address_stable", Address_Com, t_addr);
            end
            if (Bus_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_bus_done", 32'(Grant), 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk("grant", 32'(t_grant), 32'(e.grant));
                    chk("op_line", 32'(t_lines), 32'(e.lines));
                    chk("address", t_addr, e.addr);
                    chk("shared", 32'(Shared), 32'(e.shared));
                    chk("bus_err", 32'(Bus_err), 32'(e.err));
                    chk("latency", cyc, e.lat);
                    chk("op_cycles", opc, SC);
                end
                trk  = 1'b0;
                post = 1'b1;
            end
            if (stim_done) begin
                chk("stim_timeouts", stim_timeouts, 0);
                chk("scoreboard_empty", sb_q.size(), 0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int core, input logic [1:0] op, input logic [31:0] addr);
        Bus_req[core]           = 1'b1;
        Bus_op[2*core +: 2]     = op;
        Req_address[AW*core +: AW] = addr;
    endtask

    task automatic push(input logic [3:0] g, input logic [2:0] l, input logic [31:0] a,
                        input logic sh, input logic er, input int lat);
        exp_t x;
        x.grant = g; x.lines = l; x.addr = a; x.shared = sh; x.err = er; x.lat = lat;
        sb_q.push_back(x);
    endtask

    task automatic wait_grant(input int maxc);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            if (Grant != 4'b0000) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            stim_timeouts++;
            $display("FAIL wait_grant: got no Grant within %0d cycles, expected one", maxc);
        end
    endtask

    // Waits for the owner's Bus_done, then drops that core's request.
    task automatic retire(input int maxc);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            if (Bus_done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            stim_timeouts++;
            $display("FAIL wait_done: got no Bus_done within %0d cycles, expected one", maxc);
        end
        Bus_req = Bus_req & ~Grant;
        @(negedge clk);
    endtask

    // Pulses Mem_ready during the k-th WAIT_MEM cycle of the next transaction.
    task automatic mem_pulse(input int k);
        wait_grant(10);
        repeat (1 + k) @(negedge clk);
        Mem_ready = 1'b1;
        @(negedge clk);
        Mem_ready = 1'b0;
    endtask

    initial begin
        Bus_req = '0; Bus_op = '0; Req_address = '0; Snoop_hit = '0; Mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention: cores 0,1,3 from pointer 0 -> 0,1,3; pointer ends at 0.
        set_req(0, BUS_OP_INV, 32'h0000_0100);
        set_req(1, BUS_OP_INV, 32'h0000_0200);
        set_req(3, BUS_OP_INV, 32'h0000_0300);
        push(4'b0001, 3'b100, 32'h0000_0100, 1'b0, 1'b0, 3);
        push(4'b0010, 3'b100, 32'h0000_0200, 1'b0, 1'b0, 3);
        push(4'b1000, 3'b100, 32'h0000_0300, 1'b0, 1'b0, 3);
        repeat (3) retire(20);

        // Pointer back at 0: core0 wins over core3, then core3.
        set_req(3, BUS_OP_INV, 32'h0000_0400);
        set_req(0, BUS_OP_INV, 32'h0000_0500);
        push(4'b0001, 3'b100, 32'h0000_0500, 1'b0, 1'b0, 3);
        push(4'b1000, 3'b100, 32'h0000_0400, 1'b0, 1'b0, 3);
        repeat (2) retire(20);

        // Single BusRd from core2, core1 hits, memory on 3rd WAIT_MEM cycle.
        Snoop_hit = 4'b0010;
        set_req(2, BUS_OP_BUSRD, 32'h0000_1A40);
        push(4'b0100, 3'b001, 32'h0000_1A40, 1'b1, 1'b0, 2 + 3 + 1);
        mem_pulse(3);
        retire(20);

        // Invalidate from core1, core0 and core1 hit -> Shared from core0 only.
        Snoop_hit = 4'b0011;
        set_req(1, BUS_OP_INV, 32'h0000_2000);
        push(4'b0010, 3'b100, 32'h0000_2000, 1'b1, 1'b0, 3);
        retire(20);

        // Self-hit only: core3 BusRdX.
        Snoop_hit = 4'b1000;
        set_req(3, BUS_OP_BUSRDX, 32'h0000_3000);
        push(4'b1000, 3'b010, 32'h0000_3000, 1'b0, 1'b0, 2 + 1 + 1);
        mem_pulse(1);
        retire(20);

        // Memory timeout, then Mem_ready on the last allowed cycle.
        Snoop_hit = 4'b0000;
        set_req(0, BUS_OP_BUSRD, 32'h0000_4000);
        push(4'b0001, 3'b001, 32'h0000_4000, 1'b0, 1'b1, 2 + MT + 1);
        retire(100);
        set_req(1, BUS_OP_BUSRD, 32'h0000_5000);
        push(4'b0010, 3'b001, 32'h0000_5000, 1'b0, 1'b0, 2 + MT + 1);
        mem_pulse(MT);
        retire(20);

        // Ignored op=00 request alongside nothing else: must not start a transaction.
        set_req(2, BUS_OP_NONE, 32'h0000_5500);
        repeat (4) @(negedge clk);
        Bus_req = '0;

        // Async reset during WAIT_MEM: no Bus_done; pending core0 request wins afterwards.
        set_req(2, BUS_OP_BUSRD, 32'h0000_6000);
        wait_grant(10);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        Bus_req = '0;
        set_req(0, BUS_OP_INV, 32'h0000_7000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(4'b0001, 3'b100, 32'h0000_7000, 1'b0, 1'b0, 3);
        retire(20);

        repeat (5) @(negedge clk);
        stim_done = 1'b1;
    end

endmodule
